// File: rtl/rs_syndrome.sv
// Syndrome front end of the RS(544,514) GF(2^10) decoder: 30 parallel Horner accumulators
// fed one received symbol per accepted beat, then streamed out serially, one syndrome per cycle.
module rs_syndrome #(
    parameter int N    = 544,
    parameter int NSYM = 30,
    parameter int M    = 10,
    parameter int PRIM = 'h409
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sop,
    input  logic         valid_in,
    input  logic [M-1:0] data_in,
    output logic         ready,
    output logic         synd_valid,
    output logic [4:0]   synd_idx,
    output logic [M-1:0] synd_data,
    output logic         synd_last,
    output logic         err_detected,
    output logic         abort,
    output logic [1:0]   fsm_state
);

    // Handshake: a symbol is consumed on every rising edge with valid_in=1 while in RECV, or with
    // sop&valid_in=1 while in IDLE; ready=1 only in IDLE, so a new frame must wait for ready=1.
    // The syndrome stream has no back-pressure: one synd_valid beat per cycle, NSYM beats in a row.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [M-1:0] POLY_LO  = M'(PRIM);
    localparam logic [9:0]   LAST_SYM = 10'(N - 1);
    localparam logic [9:0]   LAST_OUT = 10'(NSYM - 1);

    function automatic logic [M-1:0] gf_mul_x(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY_LO : '0);
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] x;
        acc = '0;
        x   = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) acc = acc ^ x;
            x = gf_mul_x(x);
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] p;
        p = M'(1);
        for (int k = 0; k < e; k++) p = gf_mul_x(p);
        return p;
    endfunction

    state_t       state, state_next;
    logic [9:0]   count, count_next;
    logic         abort_next;
    logic         load, shift;
    logic [M-1:0] synd   [NSYM];
    logic [M-1:0] horner [NSYM];
    logic [M-1:0] sel;
    logic         any_nz;

    // Each root's multiplier is a fixed constant, so gf_mul collapses to an XOR network.
    for (genvar g = 0; g < NSYM; g++) begin : g_root
        localparam logic [M-1:0] ROOT = alpha_pow(g);
        assign horner[g] = gf_mul(synd[g], ROOT) ^ data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            abort <= 1'b0;
            for (int i = 0; i < NSYM; i++) synd[i] <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            abort <= abort_next;
            for (int i = 0; i < NSYM; i++) begin
                if (load)       synd[i] <= data_in;
                else if (shift) synd[i] <= horner[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        abort_next = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid_in && sop) begin
                    load       = 1'b1;
                    count_next = 10'd1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (valid_in && sop) begin
                    // Early sop restarts the frame in place; the partial frame is dropped.
                    load       = 1'b1;
                    count_next = 10'd1;
                    abort_next = 1'b1;
                end else if (valid_in) begin
                    shift = 1'b1;
                    if (count == LAST_SYM) begin
                        count_next = '0;
                        state_next = OUT;
                    end else begin
                        count_next = count + 10'd1;
                    end
                end
            end
            OUT: begin
                if (count == LAST_OUT) begin
                    count_next = '0;
                    state_next = IDLE;
                end else begin
                    count_next = count + 10'd1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        sel    = '0;
        any_nz = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            if (count[4:0] == 5'(i)) sel = synd[i];
            any_nz = any_nz | (|synd[i]);
        end
    end

    // Stale accumulators stay in the registers after OUT; every output is gated to zero outside OUT.
    assign ready        = (state == IDLE);
    assign synd_valid   = (state == OUT);
    assign synd_idx     = synd_valid ? count[4:0] : 5'd0;
    assign synd_data    = synd_valid ? sel : '0;
    assign synd_last    = synd_valid && (count == LAST_OUT);
    assign err_detected = synd_valid && any_nz;
    assign fsm_state    = state;

endmodule

// File: tb/tb_rs_syndrome.sv
// Directed bench for rs_syndrome: known frames, generator-polynomial codewords, early sop, resets.
module tb_rs_syndrome;
    localparam int N    = 544;
    localparam int NSYM = 30;
    localparam int M    = 10;

    logic         clk = 1'b0;
    logic         rst, sop, valid_in;
    logic [M-1:0] data_in;
    logic         ready, synd_valid, synd_last, err_detected, abort;
    logic [4:0]   synd_idx;
    logic [M-1:0] synd_data;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;

    logic [M-1:0] exp_q[$];
    logic [M-1:0] exp_t [1023];
    int           log_t [1024];
    logic [M-1:0] gpoly [NSYM+1];
    logic [M-1:0] frame [N];

    logic [M-1:0] got_data [NSYM];
    logic [4:0]   got_idx  [NSYM];
    logic         got_last [NSYM];
    logic         got_err  [NSYM];
    logic         got_vld  [NSYM];
    logic         post_valid, post_ready;
    int           wait_cyc;

    rs_syndrome dut (
        .clk(clk), .rst(rst), .sop(sop), .valid_in(valid_in), .data_in(data_in),
        .ready(ready), .synd_valid(synd_valid), .synd_idx(synd_idx), .synd_data(synd_data),
        .synd_last(synd_last), .err_detected(err_detected), .abort(abort), .fsm_state(fsm_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // GF(2^10) reference arithmetic built from log/antilog tables
    task automatic build_tables();
        int x;
        x = 1;
        for (int e = 0; e < 1023; e++) begin
            exp_t[e] = 10'(x);
            log_t[x] = e;
            x = x << 1;
            if ((x & 'h400) != 0) x = x ^ 'h409;
        end
    endtask

    function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
        if (a == '0 || b == '0) return '0;
        return exp_t[(log_t[a] + log_t[b]) % 1023];
    endfunction

    task automatic build_gpoly();
        for (int d = 0; d <= NSYM; d++) gpoly[d] = '0;
        gpoly[0] = 10'd1;
        for (int i = 0; i < NSYM; i++) begin
            for (int d = i + 1; d >= 1; d--) gpoly[d] = gpoly[d-1] ^ gmul(gpoly[d], exp_t[i]);
            gpoly[0] = gmul(gpoly[0], exp_t[i]);
        end
    endtask

    // Valid codeword c(x) = m(x) g(x) with random m(x) of degree N-NSYM-1.
    task automatic make_codeword();
        logic [M-1:0] c [N];
        logic [M-1:0] m;
        for (int j = 0; j < N; j++) c[j] = '0;
        for (int a = 0; a < N - NSYM; a++) begin
            m = 10'($urandom_range(0, 1023));
            for (int d = 0; d <= NSYM; d++) c[a+d] = c[a+d] ^ gmul(m, gpoly[d]);
        end
        for (int j = 0; j < N; j++) frame[j] = c[N-1-j];
    endtask

    // Direct evaluation S_i = sum_j r_j * alpha^(i*(N-1-j)), pushed to the expected queue.
    task automatic model_push();
        logic [M-1:0] s;
        for (int i = 0; i < NSYM; i++) begin
            s = '0;
            for (int j = 0; j < N; j++)
                if (frame[j] != '0) s = s ^ exp_t[(log_t[frame[j]] + i * (N - 1 - j)) % 1023];
            exp_q.push_back(s);
        end
    endtask

    // Driver tasks
    task automatic send_sym(input logic s, input logic [M-1:0] d);
        valid_in = 1'b1;
        sop      = s;
        data_in  = d;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sop      = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        for (int j = 0; j < N; j++) begin
            if (j > 0 && gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send_sym(j == 0, frame[j]);
        end
    endtask

    task automatic capture_out();
        wait_cyc = 0;
        while (!synd_valid && wait_cyc < 2000) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        for (int k = 0; k < NSYM; k++) begin
            got_vld[k]  = synd_valid;
            got_data[k] = synd_data;
            got_idx[k]  = synd_idx;
            got_last[k] = synd_last;
            got_err[k]  = err_detected;
            @(posedge clk);
            #1;
        end
        post_valid = synd_valid;
        post_ready = ready;
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1; sop = 1'b0; valid_in = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || synd_valid !== 1'b0 || synd_idx !== 5'd0 || synd_data !== '0 ||
            synd_last !== 1'b0 || err_detected !== 1'b0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL reset: got ready=%b valid=%b idx=%0d data=%h last=%b err=%b abort=%b, expected 1 0 0 000 0 0 0",
                     ready, synd_valid, synd_idx, synd_data, synd_last, err_detected, abort);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_zero();
        logic [M-1:0] e;
        for (int j = 0; j < N; j++) frame[j] = '0;
        for (int i = 0; i < NSYM; i++) exp_q.push_back('0);
        send_frame(0);
        capture_out();
        checks++;
        if (wait_cyc !== 0) begin
            errors++;
            $display("FAIL all_zero latency: synd_valid after %0d extra cycles, expected 0", wait_cyc);
        end
        for (int k = 0; k < NSYM; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_vld[k] !== 1'b1 || got_data[k] !== e || got_idx[k] !== 5'(k) ||
                got_last[k] !== (k == NSYM - 1) || got_err[k] !== 1'b0) begin
                errors++;
                $display("FAIL all_zero[%0d]: got v=%b d=%h i=%0d l=%b e=%b, expected v=1 d=%h i=%0d l=%b e=0",
                         k, got_vld[k], got_data[k], got_idx[k], got_last[k], got_err[k], e, k, k == NSYM - 1);
            end
        end
        checks++;
        if (post_valid !== 1'b0 || post_ready !== 1'b1) begin
            errors++;
            $display("FAIL all_zero exit: got valid=%b ready=%b, expected 0 1", post_valid, post_ready);
        end
    endtask

    task automatic test_last_symbol();
        logic [M-1:0] e;
        for (int j = 0; j < N; j++) frame[j] = '0;
        frame[N-1] = 10'h155;
        for (int i = 0; i < NSYM; i++) exp_q.push_back(10'h155);
        send_frame(2);
        capture_out();
        for (int k = 0; k < NSYM; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_vld[k] !== 1'b1 || got_data[k] !== e || got_idx[k] !== 5'(k) ||
                got_last[k] !== (k == NSYM - 1) || got_err[k] !== 1'b1) begin
                errors++;
                $display("FAIL last_symbol[%0d]: got v=%b d=%h i=%0d l=%b e=%b, expected v=1 d=%h i=%0d l=%b e=1",
                         k, got_vld[k], got_data[k], got_idx[k], got_last[k], got_err[k], e, k, k == NSYM - 1);
            end
        end
    endtask

    task automatic test_first_symbol();
        logic [M-1:0] e;
        for (int j = 0; j < N; j++) frame[j] = '0;
        frame[0] = 10'h001;
        model_push();
        send_frame(0);
        capture_out();
        checks++;
        if (got_data[0] !== 10'h001 || got_data[1] !== exp_t[543]) begin
            errors++;
            $display("FAIL first_symbol S0/S1: got %h %h, expected 001 %h", got_data[0], got_data[1], exp_t[543]);
        end
        for (int k = 0; k < NSYM; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_data[k] !== e || got_idx[k] !== 5'(k) || got_err[k] !== 1'b1) begin
                errors++;
                $display("FAIL first_symbol[%0d]: got d=%h i=%0d e=%b, expected d=%h i=%0d e=1",
                         k, got_data[k], got_idx[k], got_err[k], e, k);
            end
        end
    endtask

    task automatic test_codeword();
        logic [M-1:0] e;
        logic         exp_err;
        for (int pass = 0; pass < 2; pass++) begin
            make_codeword();
            exp_err = (pass == 1);
            if (pass == 0) begin
                for (int i = 0; i < NSYM; i++) exp_q.push_back('0);
            end else begin
                frame[$urandom_range(0, N - 1)] ^= 10'($urandom_range(1, 1023));
                model_push();
            end
            send_frame(3);
            capture_out();
            for (int k = 0; k < NSYM; k++) begin
                e = exp_q.pop_front();
                checks++;
                if (got_vld[k] !== 1'b1 || got_data[k] !== e || got_idx[k] !== 5'(k) ||
                    got_last[k] !== (k == NSYM - 1) || got_err[k] !== exp_err) begin
                    errors++;
                    $display("FAIL codeword%0d[%0d]: got v=%b d=%h i=%0d l=%b e=%b, expected v=1 d=%h i=%0d l=%b e=%b",
                             pass, k, got_vld[k], got_data[k], got_idx[k], got_last[k], got_err[k],
                             e, k, k == NSYM - 1, exp_err);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [M-1:0] e;
        for (int j = 0; j < 200; j++) send_sym(j == 0, 10'($urandom_range(0, 1023)));
        checks++;
        if (abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got %b, expected 0", abort);
        end
        make_codeword();
        frame[100] ^= 10'h2a5;
        model_push();
        send_sym(1'b1, frame[0]);
        checks++;
        if (abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse: got %b, expected 1", abort);
        end
        send_sym(1'b0, frame[1]);
        checks++;
        if (abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_width: got %b, expected 0", abort);
        end
        for (int j = 2; j < N; j++) send_sym(1'b0, frame[j]);
        capture_out();
        for (int k = 0; k < NSYM; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_data[k] !== e || got_idx[k] !== 5'(k) || got_err[k] !== 1'b1) begin
                errors++;
                $display("FAIL abort_frame[%0d]: got d=%h i=%0d e=%b, expected d=%h i=%0d e=1",
                         k, got_data[k], got_idx[k], got_err[k], e, k);
            end
        end
    endtask

    task automatic test_rst_mid_recv();
        for (int j = 0; j < N; j++) frame[j] = 10'($urandom_range(0, 1023));
        for (int j = 0; j < 300; j++) send_sym(j == 0, frame[j]);
        // Reset lands together with an early sop; reset must win.
        rst = 1'b1; valid_in = 1'b1; sop = 1'b1; data_in = 10'h3ff;
        @(posedge clk);
        #1;
        rst = 1'b0; valid_in = 1'b0; sop = 1'b0;
        checks++;
        if (ready !== 1'b1 || synd_valid !== 1'b0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_recv: got ready=%b valid=%b abort=%b, expected 1 0 0", ready, synd_valid, abort);
        end
    endtask

    task automatic test_rst_mid_out();
        int n;
        make_codeword();
        frame[7] ^= 10'h001;
        send_frame(0);
        n = 0;
        while (!(synd_valid && synd_idx == 5'd10) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL rst_mid_out wait: got no synd_idx=10 within %0d cycles, expected it", n);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || synd_valid !== 1'b0 || abort !== 1'b0 || err_detected !== 1'b0 || synd_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_out: got ready=%b valid=%b abort=%b err=%b data=%h, expected 1 0 0 0 000",
                     ready, synd_valid, abort, err_detected, synd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [M-1:0] e;
        make_codeword();
        frame[N-2] ^= 10'h0f0;
        model_push();
        send_frame(0);
        // Hammer sop/valid_in during OUT: it must be ignored and dropped.
        for (int k = 0; k < NSYM; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (synd_valid !== 1'b1 || synd_data !== e || synd_idx !== 5'(k) || ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_out[%0d]: got v=%b d=%h i=%0d r=%b, expected v=1 d=%h i=%0d r=0",
                         k, synd_valid, synd_data, synd_idx, ready, e, k);
            end
            valid_in = 1'b1; sop = 1'b1; data_in = 10'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0; sop = 1'b0;
        checks++;
        if (ready !== 1'b1 || synd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop: got ready=%b valid=%b, expected 1 0", ready, synd_valid);
        end
        repeat (5) send_sym(1'b0, 10'h3ff);
        checks++;
        if (ready !== 1'b1 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_nosop: got ready=%b state=%0d, expected 1 0", ready, fsm_state);
        end
    endtask

    initial begin
        build_tables();
        build_gpoly();
        test_reset();
        test_all_zero();
        test_last_symbol();
        test_first_symbol();
        test_codeword();
        test_abort();
        test_rst_mid_recv();
        test_last_symbol();
        test_rst_mid_out();
        test_first_symbol();
        test_back_to_back();
        test_all_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
